// File: rtl/controle_pkg.sv
// ---------------------------------------------------------------
// controle_pkg -- state, opcode, funct and ALU-code constants | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package controle_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'b0000,
    DECODE = 4'b0001,
    EXEC_R = 4'b0101,
    EXEC_I = 4'b0110,
    EXEC_B = 4'b0111,
    MEM_RD = 4'b1000,
    MEM_WR = 4'b1001,
    WB_ALU = 4'b1010,
    WB_MEM = 4'b1011,
    PC_UPD = 4'b1100,
    HALT   = 4'b1110
  } estado_t;

  localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_OP_ADDI   = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;

  localparam logic [2:0] C_F3_ADD_SUB = 3'b000;
  localparam logic [2:0] C_F3_AND     = 3'b111;
  localparam logic [2:0] C_F3_OR      = 3'b110;
  localparam logic [2:0] C_F3_XOR     = 3'b100;
  localparam logic [2:0] C_F3_SRL     = 3'b101;
  localparam logic [2:0] C_F3_ADDI    = 3'b000;
  localparam logic [2:0] C_F3_WORD    = 3'b010;
  localparam logic [2:0] C_F3_BEQ     = 3'b000;

  localparam logic [6:0] C_F7_BASE = 7'b0000000;
  localparam logic [6:0] C_F7_ALT  = 7'b0100000;

  localparam logic [3:0] C_ALU_AND  = 4'b0000;
  localparam logic [3:0] C_ALU_OR   = 4'b0001;
  localparam logic [3:0] C_ALU_ADD  = 4'b0010;
  localparam logic [3:0] C_ALU_ADDI = 4'b0011;
  localparam logic [3:0] C_ALU_XOR  = 4'b0100;
  localparam logic [3:0] C_ALU_SRL  = 4'b0101;
  localparam logic [3:0] C_ALU_SUB  = 4'b0110;

endpackage

`default_nettype wire

// File: rtl/decodificador_instrucao.sv
// ---------------------------------------------------------------
// decodificador_instrucao -- combinational RV32 subset decoder | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module decodificador_instrucao
  import controle_pkg::*;
(
  input  logic [31:0] instruction_i,
  output logic [3:0]  alucontrol_o,
  output logic        alusrc_o,
  output logic        branch_o,
  output logic [11:0] immediate_o,
  output estado_t     next_exec_o,
  output logic        illegal_o
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_unused_rs1;

  assign w_opcode     = instruction_i[6:0];
  assign w_funct3     = instruction_i[14:12];
  assign w_funct7     = instruction_i[31:25];
  // Register indices are extracted by the FSM, not here.
  assign w_unused_rs1 = instruction_i[19:15];

  always_comb begin
    alucontrol_o = C_ALU_ADD;
    alusrc_o     = 1'b0;
    branch_o     = 1'b0;
    immediate_o  = instruction_i[31:20];
    next_exec_o  = HALT;
    illegal_o    = 1'b1;

    case (w_opcode)
      C_OP_RTYPE: begin
        illegal_o   = 1'b0;
        next_exec_o = EXEC_R;
        case (w_funct3)
          C_F3_ADD_SUB: begin
            if (w_funct7 == C_F7_BASE)     alucontrol_o = C_ALU_ADD;
            else if (w_funct7 == C_F7_ALT) alucontrol_o = C_ALU_SUB;
            else                           illegal_o    = 1'b1;
          end
          C_F3_AND: alucontrol_o = C_ALU_AND;
          C_F3_OR:  alucontrol_o = C_ALU_OR;
          C_F3_XOR: alucontrol_o = C_ALU_XOR;
          C_F3_SRL: begin
            if (w_funct7 == C_F7_BASE) alucontrol_o = C_ALU_SRL;
            else                       illegal_o    = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
      C_OP_ADDI: begin
        if (w_funct3 == C_F3_ADDI) begin
          illegal_o    = 1'b0;
          alucontrol_o = C_ALU_ADDI;
          alusrc_o     = 1'b1;
          next_exec_o  = EXEC_I;
        end
      end
      C_OP_LOAD: begin
        if (w_funct3 == C_F3_WORD) begin
          illegal_o    = 1'b0;
          alucontrol_o = C_ALU_ADD;
          alusrc_o     = 1'b1;
          next_exec_o  = EXEC_I;
        end
      end
      C_OP_STORE: begin
        if (w_funct3 == C_F3_WORD) begin
          illegal_o    = 1'b0;
          alucontrol_o = C_ALU_ADD;
          alusrc_o     = 1'b1;
          immediate_o  = {instruction_i[31:25], instruction_i[11:7]};
          next_exec_o  = EXEC_I;
        end
      end
      C_OP_BRANCH: begin
        if (w_funct3 == C_F3_BEQ) begin
          illegal_o    = 1'b0;
          alucontrol_o = C_ALU_SUB;
          alusrc_o     = 1'b1;
          branch_o     = 1'b1;
          next_exec_o  = EXEC_B;
        end
      end
      default: illegal_o = 1'b1;
    endcase

    if (illegal_o) next_exec_o = HALT;
  end

endmodule

`default_nettype wire

// File: rtl/controle_multiciclo.sv
// ---------------------------------------------------------------
// controle_multiciclo -- multicycle RISC-V control FSM, Moore outputs | rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int BRANCH_EXEC_CYCLES = 3,
  parameter int MEM_WAIT_MAX       = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        pcsrc,
  output logic [3:0]  estado,
  output logic [3:0]  alucontrol,
  output logic        alusrc,
  output logic        branch,
  output logic [11:0] immediate,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        irwrite,
  output logic        regwrite,
  output logic        memtoreg,
  output logic        memread,
  output logic        memwrite,
  output logic        pcwrite,
  output logic        pcsel,
  output logic        halted
);

  localparam int WAIT_W  = $clog2(MEM_WAIT_MAX + 1);
  localparam int DWELL_W = $clog2(BRANCH_EXEC_CYCLES + 1);

  estado_t             estado_q, estado_d;
  logic [31:0]         ir_q, ir_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DWELL_W-1:0]  dwell_q, dwell_d;
  logic [3:0]          alucontrol_q, alucontrol_d;
  logic                alusrc_q, alusrc_d;
  logic                branch_q, branch_d;
  logic [11:0]         immediate_q, immediate_d;
  logic [4:0]          rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                irwrite_q, irwrite_d;
  logic                regwrite_q, regwrite_d;
  logic                memtoreg_q, memtoreg_d;
  logic                memread_q, memread_d;
  logic                memwrite_q, memwrite_d;
  logic                pcwrite_q, pcwrite_d;
  logic                pcsel_q, pcsel_d;
  logic                halted_q, halted_d;

  logic [3:0]  w_dec_alu;
  logic        w_dec_alusrc;
  logic        w_dec_branch;
  logic [11:0] w_dec_imm;
  estado_t     w_dec_next;
  logic        w_dec_illegal;
  logic        w_wait_expired;
  logic        w_dwell_done;

  decodificador_instrucao u_dec (
    .instruction_i (ir_q),
    .alucontrol_o  (w_dec_alu),
    .alusrc_o      (w_dec_alusrc),
    .branch_o      (w_dec_branch),
    .immediate_o   (w_dec_imm),
    .next_exec_o   (w_dec_next),
    .illegal_o     (w_dec_illegal)
  );

  // The last permitted wait cycle; a ready arriving on it still wins.
  assign w_wait_expired = (wait_q == WAIT_W'(MEM_WAIT_MAX - 1));
  assign w_dwell_done   = (dwell_q == DWELL_W'(BRANCH_EXEC_CYCLES - 1));

  always_comb begin
    estado_d     = estado_q;
    ir_d         = ir_q;
    wait_d       = '0;
    dwell_d      = '0;
    alucontrol_d = alucontrol_q;
    alusrc_d     = alusrc_q;
    branch_d     = branch_q;
    immediate_d  = immediate_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;

    case (estado_q)
      FETCH: begin
        if (imem_ready) begin
          ir_d     = instruction;
          estado_d = DECODE;
        end else if (w_wait_expired) begin
          estado_d = HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DECODE: begin
        alucontrol_d = w_dec_alu;
        alusrc_d     = w_dec_alusrc;
        branch_d     = w_dec_branch;
        immediate_d  = w_dec_imm;
        rs1_d        = ir_q[19:15];
        rs2_d        = ir_q[24:20];
        rd_d         = ir_q[11:7];
        estado_d     = w_dec_illegal ? HALT : w_dec_next;
      end
      EXEC_R: estado_d = WB_ALU;
      EXEC_I: begin
        case (ir_q[6:0])
          C_OP_LOAD:  estado_d = MEM_RD;
          C_OP_STORE: estado_d = MEM_WR;
          default:    estado_d = WB_ALU;
        endcase
      end
      EXEC_B: begin
        if (w_dwell_done) estado_d = PC_UPD;
        else              dwell_d  = dwell_q + 1'b1;
      end
      MEM_RD, MEM_WR: begin
        if (dmem_ready) begin
          estado_d = (estado_q == MEM_RD) ? WB_MEM : PC_UPD;
        end else if (w_wait_expired) begin
          estado_d = HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WB_ALU, WB_MEM: estado_d = PC_UPD;
      PC_UPD: begin
        estado_d = FETCH;
        branch_d = 1'b0;
      end
      HALT:    estado_d = HALT;
      default: estado_d = HALT;
    endcase

    // Moore outputs are registered as a function of the state being entered.
    irwrite_d  = (estado_d == DECODE);
    regwrite_d = (estado_d == WB_ALU) || (estado_d == WB_MEM);
    memtoreg_d = (estado_d == WB_MEM);
    memread_d  = (estado_d == MEM_RD);
    memwrite_d = (estado_d == MEM_WR);
    pcwrite_d  = (estado_d == PC_UPD);
    pcsel_d    = (estado_d == PC_UPD) && pcsrc && branch_q;
    halted_d   = (estado_d == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= FETCH;
      ir_q         <= '0;
      wait_q       <= '0;
      dwell_q      <= '0;
      alucontrol_q <= '0;
      alusrc_q     <= 1'b0;
      branch_q     <= 1'b0;
      immediate_q  <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      irwrite_q    <= 1'b0;
      regwrite_q   <= 1'b0;
      memtoreg_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      pcwrite_q    <= 1'b0;
      pcsel_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      ir_q         <= ir_d;
      wait_q       <= wait_d;
      dwell_q      <= dwell_d;
      alucontrol_q <= alucontrol_d;
      alusrc_q     <= alusrc_d;
      branch_q     <= branch_d;
      immediate_q  <= immediate_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      irwrite_q    <= irwrite_d;
      regwrite_q   <= regwrite_d;
      memtoreg_q   <= memtoreg_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      pcwrite_q    <= pcwrite_d;
      pcsel_q      <= pcsel_d;
      halted_q     <= halted_d;
    end
  end

  assign estado     = estado_q;
  assign alucontrol = alucontrol_q;
  assign alusrc     = alusrc_q;
  assign branch     = branch_q;
  assign immediate  = immediate_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign rd         = rd_q;
  assign irwrite    = irwrite_q;
  assign regwrite   = regwrite_q;
  assign memtoreg   = memtoreg_q;
  assign memread    = memread_q;
  assign memwrite   = memwrite_q;
  assign pcwrite    = pcwrite_q;
  assign pcsel      = pcsel_q;
  assign halted     = halted_q;

endmodule

`default_nettype wire
